merge_accum_mc: RTL

// Parametrised multi-channel successor to the single-register merge accumulator.

---
 rtl/merge_accum_mc.sv | 122 ++++++++++++
 1 files changed

// File: rtl/merge_accum_mc.sv
// Multi-channel merge accumulator: per-channel running sums with wrap/saturate
// overflow handling and a valid/ready flush that streams out and clears every channel.
module merge_accum_mc #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 16,
  parameter int N_CH   = 4,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mode,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CH_W-1:0]   o_ch,
  output logic [ACC_W-1:0]  o_data,
  output logic              o_ovf
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DUMP = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [CH_W-1:0]            r_ptr;
  logic [CH_W-1:0]            w_ptr_next;
  logic [N_CH-1:0][ACC_W-1:0] r_acc;
  logic [N_CH-1:0]            r_ovf;
  logic [N_CH-1:0][ACC_W:0]   w_sum;
  logic [ACC_W:0]             w_ext;
  logic                       w_accept;
  logic                       w_ch_ok;
  logic                       w_upd;
  logic                       w_xfer;
  logic                       w_last;

  assign w_accept = i_valid && o_ready;
  assign w_ch_ok  = ({{(32-CH_W){1'b0}}, i_ch} < 32'(N_CH));
  assign w_upd    = w_accept && (i_data != '0) && w_ch_ok;
  assign w_xfer   = (r_state == S_DUMP) && i_ready;
  assign w_last   = (r_ptr == CH_W'(N_CH - 1));
  assign w_ext    = {{(ACC_W + 1 - DATA_W){1'b0}}, i_data};

  // One extra bit per sum exposes the carry used for the sticky overflow flag.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_sum
    assign w_sum[gi] = {1'b0, r_acc[gi]} + w_ext;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (i_flush) begin
          w_state_next = S_DUMP;
          w_ptr_next   = '0;
        end
      end
      S_DUMP: begin
        if (w_xfer) begin
          if (w_last) begin
            w_state_next = S_IDLE;
            w_ptr_next   = '0;
          end else begin
            w_ptr_next = r_ptr + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_ptr_next   = '0;
      end
    endcase
  end

  // Accepts happen only in IDLE and transfers only in DUMP, so they never collide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_xfer && (r_ptr == CH_W'(i))) begin
          r_acc[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (w_upd && (i_ch == CH_W'(i))) begin
          if (w_sum[i][ACC_W]) begin
            r_ovf[i] <= 1'b1;
            r_acc[i] <= i_mode ? {ACC_W{1'b1}} : w_sum[i][ACC_W-1:0];
          end else begin
            r_acc[i] <= w_sum[i][ACC_W-1:0];
          end
        end
      end
    end
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_busy  = (r_state == S_DUMP);
  assign o_valid = (r_state == S_DUMP);
  assign o_ch    = (r_state == S_DUMP) ? r_ptr : '0;
  assign o_data  = (r_state == S_DUMP) ? r_acc[r_ptr] : '0;
  assign o_ovf   = (r_state == S_DUMP) ? r_ovf[r_ptr] : 1'b0;

endmodule
